// File: rtl/io_dec_printer.sv
// Prints each 64-bit value written by the CPU as unsigned decimal ASCII followed by a terminator byte.
// Incoming values are queued in a small FIFO and converted by a serial double-dabble engine.
//
// state | meaning
// IDLE  | waiting for a queued value; pops the FIFO head into the converter
// CONV  | 64 double-dabble iterations, binary -> 20-digit BCD
// EMIT  | presenting BCD digits, most significant non-zero digit first
// EOL   | presenting the terminator byte
module io_dec_printer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_write,
  input  logic [63:0] io_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONV, EMIT, EOL} state_t;

  state_t      state, state_nxt;
  logic        io_write_q;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, write_edge, push, pop;

  logic [63:0] bin, bin_shift;
  logic [79:0] bcd, bcd_adj, bcd_shift;
  logic [5:0]  conv_cnt;
  logic [4:0]  dig_idx, lead_idx;
  logic [3:0]  cur_digit;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign write_edge = io_write && !io_write_q;
  assign pop        = (state == IDLE) && !empty;
  assign push       = write_edge && (!full || pop);
  assign busy       = !empty || (state != IDLE);
  assign cur_digit  = bcd[{dig_idx, 2'b00} +: 4];

  // One double-dabble step; lead_idx finds the top non-zero digit of the step result
  // so the final iteration can hand EMIT its start position without a skip cycle.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 20; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj[78:0], bin, 1'b0};
    lead_idx = '0;
    for (int i = 0; i < 20; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) lead_idx = 5'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: if (!empty) state_nxt = CONV;
      CONV: if (conv_cnt == 6'd0) state_nxt = EMIT;
      EMIT: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, cur_digit};
        if (tx_ready && dig_idx == 5'd0) state_nxt = EOL;
      end
      EOL: begin
        tx_valid = 1'b1;
        tx_data  = EOL_CHAR;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_write_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      bin        <= '0;
      bcd        <= '0;
      conv_cnt   <= '0;
      dig_idx    <= '0;
    end else begin
      io_write_q <= io_write;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      else if (write_edge && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      case (state)
        IDLE: if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          bin      <= mem[rd_ptr[AW-1:0]];
          bcd      <= '0;
          conv_cnt <= 6'd63;
        end
        CONV: begin
          bin      <= bin_shift;
          bcd      <= bcd_shift;
          conv_cnt <= conv_cnt - 6'd1;
          if (conv_cnt == 6'd0) dig_idx <= lead_idx;
        end
        EMIT: if (tx_ready && dig_idx != 5'd0) dig_idx <= dig_idx - 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_dec_printer.sv
// Self-checking bench for io_dec_printer: expected byte stream kept in a scoreboard queue,
// filled from decimal strings in a vector table and popped as bytes are accepted.
module tb_io_dec_printer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_write;
  logic [63:0] io_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic       hold;
  logic [7:0] hold_data;
  logic       rand_ready = 1'b0;

  typedef struct {
    logic [63:0]  value;
    logic [159:0] digits;
    int           nbytes;
  } vec_t;
  vec_t vecs [6];

  io_dec_printer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_write (io_write),
    .io_data  (io_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [159:0] s);
    logic [7:0] b;
    for (int i = 19; i >= 0; i--) begin
      b = s[8*i +: 8];
      if (b != 8'h00) exp_q.push_back(b);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic send(input logic [63:0] v);
    @(posedge clk); #1;
    io_data  = v;
    io_write = 1'b1;
    @(posedge clk); #1;
    io_write = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s timeout: pending=%0d busy=%0b expected pending=0 busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checks++;
        if (!tx_valid || tx_data !== hold_data) begin
          errors++;
          $display("FAIL stall_stable: got valid=%0b data=%0h expected valid=1 data=%0h", tx_valid, tx_data, hold_data);
        end
      end
      hold      = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL byte: got %0h expected %0h", tx_data, e);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    vecs[0].value = 64'd0;                   vecs[0].digits = 160'("0");                    vecs[0].nbytes = 2;
    vecs[1].value = 64'd12345;               vecs[1].digits = 160'("12345");                vecs[1].nbytes = 6;
    vecs[2].value = 64'hFFFF_FFFF_FFFF_FFFF; vecs[2].digits = 160'("18446744073709551615"); vecs[2].nbytes = 21;
    vecs[3].value = 64'd9;                   vecs[3].digits = 160'("9");                    vecs[3].nbytes = 2;
    vecs[4].value = 64'd10;                  vecs[4].digits = 160'("10");                   vecs[4].nbytes = 3;
    vecs[5].value = 64'd1000000007;          vecs[5].digits = 160'("1000000007");           vecs[5].nbytes = 11;

    rst_n    = 1'b0;
    io_write = 1'b0;
    io_data  = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data",  64'(tx_data),  64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table: latency, back-to-back bytes and final idle for each value.
    foreach (vecs[k]) begin
      push_expected(vecs[k].digits);
      send(vecs[k].value);
      repeat (64) @(posedge clk);
      #1;
      chk("latency_not_early", 64'(tx_valid), 64'd0);
      for (int j = 0; j < vecs[k].nbytes; j++) begin
        @(posedge clk); #1;
        if (j < vecs[k].nbytes - 1 || tx_valid)
          chk("no_bubble", 64'(tx_valid), 64'd1);
      end
      wait_idle(300, "table");
      chk("table_busy_low", 64'(busy), 64'd0);
    end

    // Random back-pressure.
    rand_ready = 1'b1;
    push_expected(160'("12345"));
    send(64'd12345);
    wait_idle(800, "random_ready");
    rand_ready = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;

    // Overflow: 1 goes to the converter, 2..5 fill the FIFO, 6 is dropped.
    tx_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      if (v <= 5) push_expected(160'(8'h30 + v));
      send(64'(v));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("overflow_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("overflow_busy",     64'(busy),     64'd1);
    repeat (70) @(posedge clk);
    #1;
    chk("stalled_valid", 64'(tx_valid), 64'd1);
    chk("stalled_data",  64'(tx_data),  64'h31);
    tx_ready = 1'b1;
    wait_idle(1000, "overflow");

    // Level held high for ten cycles yields one value.
    push_expected(160'("42"));
    @(posedge clk); #1;
    io_data  = 64'd42;
    io_write = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    io_write = 1'b0;
    wait_idle(300, "held_write");
    repeat (100) @(posedge clk);
    #1;
    chk("held_no_extra", 64'(busy), 64'd0);
    chk("held_drop_cnt", 64'(drop_cnt), 64'd1);

    // Reset mid-EMIT; io_write high across release counts as an edge.
    push_expected(160'("12345"));
    send(64'd12345);
    begin
      int n = 0;
      while (exp_q.size() > 3 && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      chk("mid_emit_reached", 64'(exp_q.size() <= 3), 64'd1);
    end
    #2;
    rst_n    = 1'b0;
    io_data  = 64'd7;
    io_write = 1'b1;
    #1;
    chk("async_rst_valid", 64'(tx_valid), 64'd0);
    chk("async_rst_data",  64'(tx_data),  64'd0);
    chk("async_rst_busy",  64'(busy),     64'd0);
    chk("async_rst_drop",  64'(drop_cnt), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    push_expected(160'("7"));
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    io_write = 1'b0;
    wait_idle(300, "after_reset");
    chk("after_reset_drop", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
